// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage driving the producer side of IF/ID.
// Owns the PC and issues one instruction-memory read at a time. A returned
// instruction is buffered while decode stalls, and a wrong-path fetch is
// discarded when a redirect arrives.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter int unsigned      width    = 32,
    parameter logic [width-1:0] RESET_PC = 32'h4000_0060
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [width-1:0] redirect_pc_i,
    input  logic             imem_resp_i,
    input  logic [width-1:0] imem_rdata_i,
    output logic             imem_read_o,
    output logic [width-1:0] imem_address_o,
    output logic [width-1:0] if_pc_o,
    output logic [width-1:0] if_instr_o,
    output logic             if_load_o,
    output logic             if_flush_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched_o,
    output logic [31:0]      perf_stall_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t           state_q, state_d;
    logic [width-1:0] pc_q, pc_d;
    logic [width-1:0] target_q, target_d;
    logic [width-1:0] ibuf_q, ibuf_d;
    logic [width-1:0] redir_pc;

    // Redirect targets are word aligned.
    assign redir_pc = redirect_pc_i & ~{{(width-2){1'b0}}, 2'b11};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            target_q <= '0;
            ibuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            ibuf_q   <= ibuf_d;
        end
    end

    // Next-state and output logic; redirect outranks stall and response.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        target_d       = target_q;
        ibuf_d         = ibuf_q;
        imem_read_o    = 1'b0;
        imem_address_o = pc_q;
        if_pc_o        = pc_q;
        if_instr_o     = '0;
        if_load_o      = 1'b0;
        if_flush_o     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                imem_read_o = 1'b1;
                if_instr_o  = imem_rdata_i;
                if (redirect_i) begin
                    if_flush_o = 1'b1;
                    if (imem_resp_i) begin
                        pc_d = redir_pc;
                    end else begin
                        target_d = redir_pc;
                        state_d  = S_DISCARD;
                    end
                end else if (imem_resp_i) begin
                    if (stall_i) begin
                        ibuf_d  = imem_rdata_i;
                        state_d = S_HOLD;
                    end else begin
                        if_load_o = 1'b1;
                        pc_d      = pc_q + width'(4);
                    end
                end
            end
            S_HOLD: begin
                if_instr_o = ibuf_q;
                if (redirect_i) begin
                    if_flush_o = 1'b1;
                    pc_d       = redir_pc;
                    state_d    = S_REQ;
                end else if (!stall_i) begin
                    if_load_o = 1'b1;
                    pc_d      = pc_q + width'(4);
                    state_d   = S_REQ;
                end
            end
            S_DISCARD: begin
                // The outstanding request must finish at its original address;
                // its data is dropped and fetch resumes at the latest target.
                imem_read_o = 1'b1;
                if (redirect_i) begin
                    if_flush_o = 1'b1;
                    target_d   = redir_pc;
                end
                if (imem_resp_i) begin
                    pc_d    = redirect_i ? redir_pc : target_q;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, stall_q;
    logic        stall_cycle;

    assign stall_cycle    = (state_q == S_HOLD) || ((state_q == S_REQ) && !imem_resp_i);
    assign perf_fetched_o = fetched_q;
    assign perf_stall_o   = stall_q;

    // Saturating fetch/stall counters, frozen on flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else if (!if_flush_o) begin
            if (if_load_o && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
            if (stall_cycle && (stall_q != '1)) stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. Inputs change just after
// the falling edge; outputs are sampled 2 ns later, mid-cycle.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, redir = 1'b0, resp = 1'b0;
    logic [31:0] rpc = '0, rdata = '0;
    logic        read, load, flush;
    logic [31:0] addr, ipc, instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.width(32), .RESET_PC(32'h4000_0060)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir),
        .redirect_pc_i(rpc), .imem_resp_i(resp), .imem_rdata_i(rdata),
        .imem_read_o(read), .imem_address_o(addr), .if_pc_o(ipc),
        .if_instr_o(instr), .if_load_o(load), .if_flush_o(flush)
`ifdef FETCH_PERF_EN
        , .perf_fetched_o(perf_fetched), .perf_stall_o(perf_stall)
`endif
    );

    // Move to the next cycle's input-drive point.
    task automatic next_cycle;
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic rd, input logic [31:0] p,
                         input logic rs, input logic [31:0] d);
        stall = s; redir = rd; rpc = p; resp = rs; rdata = d;
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", read); end
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
        checks++; if (ipc !== 32'h4000_0060) begin errors++; $display("FAIL reset_pc: got %h expected 40000060", ipc); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetched !== 32'h0) begin errors++; $display("FAIL reset_perf_fetched: got %h expected 0", perf_fetched); end
        checks++; if (perf_stall !== 32'h0) begin errors++; $display("FAIL reset_perf_stall: got %h expected 0", perf_stall); end
`endif
        next_cycle();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL idle_read: got %b expected 0", read); end
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL idle_load: got %b expected 0", load); end
        next_cycle();
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        exp_pc = 32'h4000_0060;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i));
            checks++; if (load !== 1'b1) begin errors++; $display("FAIL stream_load c%0d: got %b expected 1", i, load); end
            checks++; if (ipc !== exp_pc) begin errors++; $display("FAIL stream_pc c%0d: got %h expected %h", i, ipc, exp_pc); end
            checks++; if (addr !== exp_pc) begin errors++; $display("FAIL stream_addr c%0d: got %h expected %h", i, addr, exp_pc); end
            checks++; if (instr !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL stream_instr c%0d: got %h expected %h", i, instr, 32'h1000 + 32'(i)); end
            next_cycle();
            exp_pc = exp_pc + 32'd4;
        end
`ifdef FETCH_PERF_EN
        #2;
        checks++; if (perf_fetched !== 32'd3) begin errors++; $display("FAIL stream_perf_fetched: got %0d expected 3", perf_fetched); end
`endif
    endtask

    task automatic test_wait_resp;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'hBAD0_0000);
            checks++; if (read !== 1'b1 || addr !== 32'h4000_0060) begin errors++; $display("FAIL wait_req c%0d: got read=%b addr=%h expected read=1 addr=40000060", i, read, addr); end
            checks++; if (load !== 1'b0) begin errors++; $display("FAIL wait_noload c%0d: got %b expected 0", i, load); end
            next_cycle();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
        checks++; if (read !== 1'b1 || addr !== 32'h4000_0060) begin errors++; $display("FAIL wait_resp_req: got read=%b addr=%h expected read=1 addr=40000060", read, addr); end
        checks++; if (load !== 1'b1 || instr !== 32'h0000_0013) begin errors++; $display("FAIL wait_resp_load: got load=%b instr=%h expected load=1 instr=00000013", load, instr); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (addr !== 32'h4000_0064) begin errors++; $display("FAIL wait_next_addr: got %h expected 40000064", addr); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetched !== 32'd1 || perf_stall !== 32'd3) begin errors++; $display("FAIL wait_perf: got fetched=%0d stall=%0d expected 1/3", perf_fetched, perf_stall); end
`endif
        next_cycle();
    endtask

    task automatic test_stall;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h00A0_0093);
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL stall_req_noload: got %b expected 0", load); end
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'hFFFF_0000);
        checks++; if (read !== 1'b0 || load !== 1'b0) begin errors++; $display("FAIL stall_hold: got read=%b load=%b expected 0/0", read, load); end
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL stall_hold_instr: got %h expected 00a00093", instr); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_0000);
        checks++; if (load !== 1'b1 || instr !== 32'h00A0_0093 || ipc !== 32'h4000_0060) begin errors++; $display("FAIL stall_release: got load=%b instr=%h pc=%h expected 1/00a00093/40000060", load, instr, ipc); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (read !== 1'b1 || addr !== 32'h4000_0064) begin errors++; $display("FAIL stall_next_addr: got read=%b addr=%h expected 1/40000064", read, addr); end
        next_cycle();
    endtask

    task automatic test_redirect_pending;
        drive(1'b0, 1'b1, 32'h4000_0103, 1'b0, 32'h0);
        checks++; if (flush !== 1'b1 || load !== 1'b0) begin errors++; $display("FAIL redir_flush: got flush=%b load=%b expected 1/0", flush, load); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (read !== 1'b1 || addr !== 32'h4000_0060 || flush !== 1'b0) begin errors++; $display("FAIL redir_discard: got read=%b addr=%h flush=%b expected 1/40000060/0", read, addr, flush); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checks++; if (load !== 1'b0 || addr !== 32'h4000_0060) begin errors++; $display("FAIL redir_drop: got load=%b addr=%h expected 0/40000060", load, addr); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (read !== 1'b1 || addr !== 32'h4000_0100) begin errors++; $display("FAIL redir_target: got read=%b addr=%h expected 1/40000100", read, addr); end
        next_cycle();
    endtask

    task automatic test_redirect_hold_and_wrap;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
        next_cycle();
        drive(1'b1, 1'b1, 32'h4000_0200, 1'b0, 32'h0);
        checks++; if (flush !== 1'b1 || load !== 1'b0) begin errors++; $display("FAIL hold_redir: got flush=%b load=%b expected 1/0", flush, load); end
        next_cycle();
        // Redirect with a same-cycle response while stalled stays in REQ.
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h2222_2222);
        checks++; if (addr !== 32'h4000_0200 || flush !== 1'b1 || load !== 1'b0) begin errors++; $display("FAIL hold_target: got addr=%h flush=%b load=%b expected 40000200/1/0", addr, flush, load); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_3333);
        checks++; if (load !== 1'b1 || ipc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_load: got load=%b pc=%h expected 1/fffffffc", load, ipc); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", addr); end
        next_cycle();
    endtask

    task automatic test_discard_latest_and_reset;
        drive(1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 32'h0000_0601, 1'b1, 32'h4444_4444);
        checks++; if (flush !== 1'b1 || load !== 1'b0 || addr !== 32'h0) begin errors++; $display("FAIL discard_redir: got flush=%b load=%b addr=%h expected 1/0/00000000", flush, load, addr); end
        next_cycle();
        drive(1'b0, 1'b1, 32'h0000_0700, 1'b0, 32'h0);
        checks++; if (addr !== 32'h0000_0600) begin errors++; $display("FAIL discard_latest: got %h expected 00000600", addr); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (read !== 1'b1) begin errors++; $display("FAIL discard_read: got %b expected 1", read); end
        rst = 1'b0;
        #1;
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL async_reset_read: got %b expected 0", read); end
        checks++; if (ipc !== 32'h4000_0060) begin errors++; $display("FAIL async_reset_pc: got %h expected 40000060", ipc); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin errors++; $display("FAIL async_reset_perf: got %0d/%0d expected 0/0", perf_fetched, perf_stall); end
`endif
        next_cycle();
        rst = 1'b1;
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (read !== 1'b1 || addr !== 32'h4000_0060) begin errors++; $display("FAIL restart_addr: got read=%b addr=%h expected 1/40000060", read, addr); end
        next_cycle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_reset();
        test_wait_resp();
        test_reset();
        test_stall();
        test_reset();
        test_redirect_pending();
        test_reset();
        test_redirect_hold_and_wrap();
        test_discard_latest_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 ns");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; drives the producer side of the IF/ID pipeline register (pc, instr, load, flush).
- Owns the PC, issues reads on the instruction-memory port and waits for each response.
- Buffers a returned instruction while decode is stalled.
- On a control-flow redirect, discards the in-flight or buffered wrong-path fetch.

Parameters:
- width, 32, datapath/PC/instruction width.
- RESET_PC, 32'h4000_0060, PC value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- stall_i  in  1  downstream hazard; decode cannot accept an instruction this cycle.
- redirect_i  in  1  taken branch/jump resolved; fetch must restart at redirect_pc_i.
- redirect_pc_i  in  width  redirect target; bits [1:0] are forced to 0 internally.
- imem_resp_i  in  1  memory response valid; may rise in the same cycle as imem_read_o.
- imem_rdata_i  in  width  instruction data, valid when imem_resp_i=1.
- imem_read_o  out  1  read request.
- imem_address_o  out  width  read address; held stable while imem_read_o=1 until imem_resp_i.
- if_pc_o  out  width  PC of the instruction presented to IF/ID.
- if_instr_o  out  width  instruction presented to IF/ID.
- if_load_o  out  1  IF/ID load enable; 1 = capture if_pc_o/if_instr_o this edge.
- if_flush_o  out  1  IF/ID flush.

Behaviour:
- Registers: pc, target (saved redirect PC), buf (instruction holding register), state.
- Reset (rst=0, async): pc=RESET_PC, target=0, buf=0, state=IDLE.
- Outputs during reset: imem_read_o=0, if_load_o=0, if_flush_o=0, if_instr_o=0, if_pc_o=RESET_PC.
- IDLE: all outputs inactive; first clock after reset release goes to REQ.
- REQ: imem_read_o=1, imem_address_o=pc, if_pc_o=pc, if_instr_o=imem_rdata_i.
  - redirect_i=1 (regardless of resp): if_flush_o=1, if_load_o=0.
    - resp=1: pc<=redirect_pc_i, stay REQ.
    - resp=0: target<=redirect_pc_i, go DISCARD.
  - resp=1, no redirect, stall_i=0: if_load_o=1 combinationally; pc<=pc+4; stay REQ.
  - resp=1, no redirect, stall_i=1: buf<=imem_rdata_i, go HOLD.
  - resp=0, no redirect: wait; address unchanged.
- HOLD: imem_read_o=0, if_instr_o=buf, if_pc_o=pc.
  - redirect_i=1: if_flush_o=1; discard buf; pc<=redirect_pc_i; go REQ.
  - stall_i=0: if_load_o=1; pc<=pc+4; go REQ.
  - Otherwise stay HOLD.
- DISCARD: imem_read_o=1 at the old address (protocol forbids an address change mid-request); if_load_o=0.
  - redirect_i=1: if_flush_o=1; target<=redirect_pc_i (latest redirect wins).
  - resp=1: data dropped; pc<=target, or redirect_pc_i if a redirect arrives the same cycle; go REQ.
- Simultaneous events:
  - redirect_i has priority over stall_i and over resp delivery.
  - if_load_o and if_flush_o are never both 1.
- Arithmetic: pc+4 wraps modulo 2^width; no carry out.
- Throughput and latency:
  - One instruction per cycle with zero-latency memory.
  - First if_load_o occurs ≥2 cycles after reset release.
  - Redirect-to-first-load ≥1 cycle.
- Reset mid-operation: immediately returns to IDLE and drops any pending request; imem_read_o falls asynchronously.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs perf_fetched_o (32) and perf_stall_o (32).
  - perf_fetched_o increments on each if_load_o=1 cycle.
  - perf_stall_o increments on each cycle in HOLD, and on REQ cycles with resp=0.
  - Both counters reset to 0 on rst, saturate at 32'hFFFF_FFFF, and do not increment during if_flush_o cycles.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory always resp=1, no stall → if_load_o=1 on consecutive cycles; if_pc_o sequence 4000_0060, 4000_0064, 4000_0068; imem_address_o matches.
- resp delayed 3 cycles at pc 4000_0060 → imem_read_o=1 and address stable 4000_0060 for 4 cycles; single if_load_o with rdata 0000_0013.
- stall_i=1 for 2 cycles at resp of 0x00A00093 → HOLD, imem_read_o=0, if_load_o=0; on stall drop, if_load_o=1 with if_instr_o=00A0_0093; next address 4000_0064.
- redirect_i with redirect_pc_i=4000_0103 while resp pending → if_flush_o=1 one cycle; old response dropped (no load); next request address 4000_0100.
- redirect in HOLD plus stall_i=1 → flush wins, buffer discarded, next address = target; separately, pc=FFFF_FFFC with load → next address 0000_0000.
- rst=0 asserted mid-DISCARD → imem_read_o=0 immediately; after release, fetch restarts at RESET_PC; with FETCH_PERF_EN, counters read 0.
